// File: rtl/comb_rv32_sequencer.sv
// comb_rv32_sequencer: multi-cycle controller around the combinational
// comb_rv32 datapath. Owns PC, register file and counters, and shares one
// native memory port between instruction fetch and the core's data access.
module comb_rv32_sequencer #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter bit          REGS_INIT_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    // external native memory port
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,

    // instruction / PC exchange with the core
    output logic [31:0] core_pc,
    output logic [31:0] core_insn,
    output logic        core_insn_valid,
    input  logic [31:0] core_pc_next,
    input  logic        core_insn_complete,
    input  logic        core_trap,

    // register file exchange with the core
    input  logic [4:0]  core_rs1_addr,
    input  logic [4:0]  core_rs2_addr,
    input  logic [4:0]  core_rd_addr,
    input  logic        core_rs1_request,
    input  logic        core_rs2_request,
    input  logic        core_rd_request,
    output logic [31:0] core_rs1_rdata,
    output logic [31:0] core_rs2_rdata,
    output logic        core_rs1_ready,
    output logic        core_rs2_ready,
    output logic        core_rd_ready,
    input  logic [31:0] core_rd_wdata,

    // core data access, forwarded to the external port during EXEC
    input  logic        core_mem_valid,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_wdata,
    input  logic [3:0]  core_mem_wstrb,
    output logic        core_mem_ready,
    output logic [31:0] core_mem_rdata,

    // counters and halt
    output logic [63:0] csr_cycle,
    output logic [63:0] csr_time,
    output logic [63:0] csr_instret,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_RD_RS1,
        S_RD_RS2,
        S_EXEC,
        S_TRAPPED
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_insn;
    logic [31:0] r_rs1_q;
    logic [31:0] r_rs2_q;
    logic [63:0] r_cycle;
    logic [63:0] r_instret;
    logic        r_trap;
    logic [31:0] r_regs [32];

    logic [4:0]  w_rf_raddr;
    logic [31:0] w_rf_rdata;
    logic        w_rf_we;
    logic        w_retire;
    logic        w_take_trap;

    // The sequence is fixed, so the core's own read addresses/requests are
    // informational only; fold them here so they are visibly consumed.
    logic        w_unused;
    assign w_unused = ^{core_rs1_addr, core_rs2_addr, core_rs1_request, core_rs2_request};

    // Completion decisions shared by the datapath and register file.
    assign w_retire    = (r_state == S_EXEC) && core_insn_complete && !core_trap;
    assign w_take_trap = (r_state == S_EXEC) && core_insn_complete && core_trap;
    assign w_rf_we     = resetn && w_retire && core_rd_request && (core_rd_addr != 5'd0);

    // Single read port; index 0 is hardwired to zero.
    assign w_rf_rdata = (w_rf_raddr == 5'd0) ? 32'd0 : r_regs[w_rf_raddr];

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_RESET;
        else         r_state <= w_state_next;
    end

    // Next-state decode and all state-dependent outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_rf_raddr      = 5'd0;
        mem_valid       = 1'b0;
        mem_instr       = 1'b0;
        mem_addr        = 32'd0;
        mem_wdata       = 32'd0;
        mem_wstrb       = 4'd0;
        core_insn_valid = 1'b0;
        core_rs1_ready  = 1'b0;
        core_rs2_ready  = 1'b0;
        core_rd_ready   = 1'b0;
        core_rs1_rdata  = 32'd0;
        core_rs2_rdata  = 32'd0;
        core_mem_ready  = 1'b0;
        core_mem_rdata  = 32'd0;

        case (r_state)
            S_RESET: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_valid = 1'b1;
                mem_instr = 1'b1;
                mem_addr  = r_pc;
                if (mem_ready) w_state_next = S_RD_RS1;
            end
            S_RD_RS1: begin
                w_rf_raddr   = r_insn[19:15];
                w_state_next = S_RD_RS2;
            end
            S_RD_RS2: begin
                w_rf_raddr   = r_insn[24:20];
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                core_insn_valid = 1'b1;
                core_rs1_ready  = 1'b1;
                core_rs2_ready  = 1'b1;
                core_rd_ready   = 1'b1;
                core_rs1_rdata  = r_rs1_q;
                core_rs2_rdata  = r_rs2_q;
                // A trapping instruction must never reach memory, but is
                // still handed a ready so it can complete.
                mem_valid       = core_mem_valid && !core_trap;
                mem_addr        = core_mem_addr;
                mem_wdata       = core_mem_wdata;
                mem_wstrb       = core_mem_wstrb;
                core_mem_rdata  = mem_rdata;
                core_mem_ready  = mem_ready || core_trap;
                if (core_insn_complete)
                    w_state_next = core_trap ? S_TRAPPED : S_FETCH;
            end
            S_TRAPPED: begin
                w_state_next = S_TRAPPED;
            end
            default: begin
                w_state_next = S_RESET;
            end
        endcase
    end

    // PC, latched instruction, operand latches, counters and trap flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc      <= PROGADDR_RESET;
            r_insn    <= 32'd0;
            r_rs1_q   <= 32'd0;
            r_rs2_q   <= 32'd0;
            r_cycle   <= 64'd0;
            r_instret <= 64'd0;
            r_trap    <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (r_state == S_FETCH && mem_ready) r_insn  <= mem_rdata;
            if (r_state == S_RD_RS1)             r_rs1_q <= w_rf_rdata;
            if (r_state == S_RD_RS2)             r_rs2_q <= w_rf_rdata;
            if (w_retire) begin
                r_pc      <= core_pc_next;
                r_instret <= r_instret + 64'd1;
            end
            if (w_take_trap) r_trap <= 1'b1;
        end
    end

    // Register file write port; x0 is never written.
    generate
        if (REGS_INIT_ZERO) begin : g_rf_reset
            // NOTE: clearing a memory on reset forces it into flops; only do
            // it when the zero-init guarantee is wanted, otherwise leave the
            // array unreset so it can map to RAM.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
                end else if (w_rf_we) begin
                    r_regs[core_rd_addr] <= core_rd_wdata;
                end
            end
        end else begin : g_rf_noreset
            always_ff @(posedge clk) begin
                if (w_rf_we) r_regs[core_rd_addr] <= core_rd_wdata;
            end
        end
    endgenerate

    assign core_pc     = r_pc;
    assign core_insn   = r_insn;
    assign csr_cycle   = r_cycle;
    assign csr_time    = r_cycle;
    assign csr_instret = r_instret;
    assign trap        = r_trap;

endmodule

// File: tb/tb_comb_rv32_sequencer.sv
// Self-checking bench for comb_rv32_sequencer: the bench plays both the
// external memory and the combinational core.
module tb_comb_rv32_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        resetn;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] core_pc, core_insn, core_pc_next;
    logic        core_insn_valid, core_insn_complete, core_trap;
    logic [4:0]  core_rs1_addr, core_rs2_addr, core_rd_addr;
    logic        core_rs1_request, core_rs2_request, core_rd_request;
    logic [31:0] core_rs1_rdata, core_rs2_rdata, core_rd_wdata;
    logic        core_rs1_ready, core_rs2_ready, core_rd_ready;
    logic        core_mem_valid, core_mem_ready;
    logic [31:0] core_mem_addr, core_mem_wdata, core_mem_rdata;
    logic [3:0]  core_mem_wstrb;
    logic [63:0] csr_cycle, csr_time, csr_instret;
    logic        trap;

    comb_rv32_sequencer #(
        .PROGADDR_RESET(RST_PC),
        .REGS_INIT_ZERO(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .core_pc(core_pc), .core_insn(core_insn), .core_insn_valid(core_insn_valid),
        .core_pc_next(core_pc_next), .core_insn_complete(core_insn_complete),
        .core_trap(core_trap),
        .core_rs1_addr(core_rs1_addr), .core_rs2_addr(core_rs2_addr),
        .core_rd_addr(core_rd_addr),
        .core_rs1_request(core_rs1_request), .core_rs2_request(core_rs2_request),
        .core_rd_request(core_rd_request),
        .core_rs1_rdata(core_rs1_rdata), .core_rs2_rdata(core_rs2_rdata),
        .core_rs1_ready(core_rs1_ready), .core_rs2_ready(core_rs2_ready),
        .core_rd_ready(core_rd_ready), .core_rd_wdata(core_rd_wdata),
        .core_mem_valid(core_mem_valid), .core_mem_addr(core_mem_addr),
        .core_mem_wdata(core_mem_wdata), .core_mem_wstrb(core_mem_wstrb),
        .core_mem_ready(core_mem_ready), .core_mem_rdata(core_mem_rdata),
        .csr_cycle(csr_cycle), .csr_time(csr_time), .csr_instret(csr_instret),
        .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        int          wait_cycles;
        logic        rd_req;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_next;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;   // cycles since last reset release
    logic [31:0] exp_pc;
    logic [63:0] exp_instret;
    vec_t        vecs [7];
    vec_t        post_reset_vec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_core();
        core_pc_next       = 32'd0;
        core_insn_complete = 1'b0;
        core_trap          = 1'b0;
        core_rs1_addr      = 5'd0;
        core_rs2_addr      = 5'd0;
        core_rd_addr       = 5'd0;
        core_rs1_request   = 1'b0;
        core_rs2_request   = 1'b0;
        core_rd_request    = 1'b0;
        core_rd_wdata      = 32'd0;
        core_mem_valid     = 1'b0;
        core_mem_addr      = 32'd0;
        core_mem_wdata     = 32'd0;
        core_mem_wstrb     = 4'd0;
    endtask

    // Starts in FETCH; returns at the first cycle of EXEC.
    task automatic fetch(input logic [31:0] insn, input int waits);
        for (int w = 0; w < waits; w++) begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_0000 + 32'(w);
            #1;
            check("fetch_wait_valid", mem_valid, 1);
            check("fetch_wait_addr", mem_addr, exp_pc);
            check("fetch_wait_instr", mem_instr, 1);
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = insn;
        #1;
        check("fetch_valid", mem_valid, 1);
        check("fetch_addr", mem_addr, exp_pc);
        check("fetch_instr", mem_instr, 1);
        check("fetch_wstrb", mem_wstrb, 0);
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        check("rd_rs1_insn", core_insn, insn);
        check("rd_rs1_idle", {mem_valid, core_insn_valid}, 0);
        step();
        check("rd_rs2_idle", {mem_valid, core_insn_valid}, 0);
        step();
    endtask

    task automatic check_exec_entry(input logic [31:0] insn, input logic [31:0] rs1,
                                    input logic [31:0] rs2);
        check("exec_insn_valid", core_insn_valid, 1);
        check("exec_readies", {core_rs1_ready, core_rs2_ready, core_rd_ready}, 3'b111);
        check("exec_insn", core_insn, insn);
        check("exec_pc", core_pc, exp_pc);
        check("exec_rs1", core_rs1_rdata, rs1);
        check("exec_rs2", core_rs2_rdata, rs2);
    endtask

    // After completion the sequencer must be back in FETCH at the new PC.
    task automatic check_back_in_fetch();
        check("next_fetch_valid", mem_valid, 1);
        check("next_fetch_instr", mem_instr, 1);
        check("next_fetch_addr", mem_addr, exp_pc);
        check("instret", csr_instret, exp_instret);
        check("cycle", csr_cycle, 64'(cyc));
    endtask

    task automatic run_vec(input vec_t v);
        fetch(v.insn, v.wait_cycles);
        check_exec_entry(v.insn, v.exp_rs1, v.exp_rs2);
        core_pc_next       = v.pc_next;
        core_rd_request    = v.rd_req;
        core_rd_addr       = v.rd_addr;
        core_rd_wdata      = v.rd_wdata;
        core_insn_complete = 1'b1;
        step();
        idle_core();
        exp_pc      = v.pc_next;
        exp_instret = exp_instret + 64'd1;
        check_back_in_fetch();
    endtask

    initial begin
        //           insn          wt rdq rd     rd_wdata       pc_next        rs1            rs2
        vecs[0] = '{32'h0050_0093, 0, 1, 5'd1,  32'd5,         32'h0000_0104, 32'd0,         32'd0};
        vecs[1] = '{32'h0010_8133, 3, 1, 5'd2,  32'd10,        32'h0000_0108, 32'd5,         32'd5};
        vecs[2] = '{32'h0011_0033, 0, 1, 5'd0,  32'hDEADBEEF,  32'h0000_010C, 32'd10,        32'd5};
        vecs[3] = '{32'h0020_01B3, 0, 1, 5'd3,  32'h1234_5678, 32'h0000_0110, 32'd0,         32'd10};
        vecs[4] = '{32'h01F1_8FB3, 1, 1, 5'd31, 32'hA5A5_A5A5, 32'h0000_0180, 32'h1234_5678, 32'd0};
        vecs[5] = '{32'h01FF_8033, 0, 0, 5'd5,  32'hFFFF_FFFF, 32'h0000_0184, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[6] = '{32'h0012_8033, 0, 0, 5'd0,  32'd0,         32'h0000_0188, 32'd0,         32'd5};
        post_reset_vec = '{32'h01FF_8033, 0, 0, 5'd0, 32'd0, 32'h0000_0104, 32'd0, 32'd0};

        resetn    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        idle_core();
        exp_pc      = RST_PC;
        exp_instret = 64'd0;

        // Reset held for three cycles.
        step(); step(); step();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_trap", trap, 0);
        check("rst_cycle", csr_cycle, 0);
        check("rst_instret", csr_instret, 0);
        check("rst_pc", core_pc, RST_PC);
        check("rst_insn", core_insn, 0);

        // Release: first fetch on the next cycle.
        resetn = 1'b1;
        cyc    = 0;
        step();
        check("first_fetch_valid", mem_valid, 1);
        check("first_fetch_addr", mem_addr, RST_PC);
        check("first_fetch_instr", mem_instr, 1);
        check("first_cycle", csr_cycle, 1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Store with two data wait cycles; no register write (x31 kept).
        fetch(32'h0020_A023, 0);
        check_exec_entry(32'h0020_A023, 32'd5, 32'd10);
        core_mem_valid  = 1'b1;
        core_mem_addr   = 32'h0000_0200;
        core_mem_wdata  = 32'hCAFE_F00D;
        core_mem_wstrb  = 4'hF;
        core_rd_request = 1'b0;
        core_rd_addr    = 5'd31;
        core_rd_wdata   = 32'd0;
        for (int w = 0; w < 2; w++) begin
            mem_ready = 1'b0;
            #1;
            check("st_valid", mem_valid, 1);
            check("st_instr", mem_instr, 0);
            check("st_addr", mem_addr, 32'h0000_0200);
            check("st_wdata", mem_wdata, 32'hCAFE_F00D);
            check("st_wstrb", mem_wstrb, 4'hF);
            check("st_core_ready_low", core_mem_ready, 0);
            step();
        end
        mem_ready          = 1'b1;
        mem_rdata          = 32'h1357_9BDF;
        core_insn_complete = 1'b1;
        core_pc_next       = 32'h0000_018C;
        #1;
        check("st_core_ready", core_mem_ready, 1);
        check("st_core_rdata", core_mem_rdata, 32'h1357_9BDF);
        step();
        idle_core();
        mem_ready   = 1'b0;
        mem_rdata   = 32'd0;
        exp_pc      = 32'h0000_018C;
        exp_instret = exp_instret + 64'd1;
        check_back_in_fetch();

        // Trapping instruction: memory untouched, state frozen.
        fetch(32'hFFFF_FFFF, 0);
        check_exec_entry(32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        core_trap          = 1'b1;
        core_mem_valid     = 1'b1;
        core_mem_addr      = 32'h0000_0300;
        core_mem_wstrb     = 4'hF;
        core_insn_complete = 1'b1;
        core_pc_next       = 32'h0000_0999;
        core_rd_request    = 1'b1;
        core_rd_addr       = 5'd31;
        core_rd_wdata      = 32'd0;
        #1;
        check("trap_mem_valid", mem_valid, 0);
        check("trap_core_ready", core_mem_ready, 1);
        step();
        idle_core();
        check("trap_set", trap, 1);
        check("trap_pc", core_pc, exp_pc);
        check("trap_instret", csr_instret, exp_instret);
        for (int i = 0; i < 5; i++) begin
            step();
            check("trapped_no_fetch", mem_valid, 0);
            check("trapped_sticky", trap, 1);
        end
        check("trapped_cycle", csr_cycle, 64'(cyc));
        check("trapped_time", csr_time, 64'(cyc));

        // Reset pulse restarts at the reset vector with cleared state.
        resetn = 1'b0;
        step();
        check("rerst_trap", trap, 0);
        check("rerst_mem_valid", mem_valid, 0);
        check("rerst_cycle", csr_cycle, 0);
        check("rerst_instret", csr_instret, 0);
        check("rerst_pc", core_pc, RST_PC);
        resetn      = 1'b1;
        cyc         = 0;
        exp_pc      = RST_PC;
        exp_instret = 64'd0;
        step();
        check("refetch_valid", mem_valid, 1);
        check("refetch_addr", mem_addr, RST_PC);
        check("refetch_instr", mem_instr, 1);
        check("refetch_cycle", csr_cycle, 1);

        // x31 must be cleared again by the reset.
        run_vec(post_reset_vec);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
